// File: rtl/ac97_cmd_sequencer.sv
// AC97 codec command sequencer: settles the link with codec-ID reads, writes
// the mixer init table one entry per frame, then re-issues headphone or record
// source writes whenever the live controls drift from the last written values.
module ac97_cmd_sequencer #(
    parameter int         VOL_W         = 5,
    parameter int         SETTLE_FRAMES = 2,
    parameter int         MIC_BOOST     = 1,
    parameter logic [4:0] PCM_ATT       = 5'h08
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ready,
    input  logic [VOL_W-1:0] volume_l,
    input  logic [VOL_W-1:0] volume_r,
    input  logic             mute,
    input  logic [2:0]       source,
    output logic [7:0]       command_address,
    output logic [15:0]      command_data,
    output logic             command_valid,
    output logic             init_done
);

    localparam logic [1:0] ST_SETTLE = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    localparam int          VOL_SHIFT   = 5 - VOL_W;
    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_FRAMES - 1);
    localparam logic [2:0]  INIT_LAST   = 3'd6;
    localparam logic [15:0] MIC_WORD    = (MIC_BOOST != 0) ? 16'h8048 : 16'h8008;
    localparam logic [7:0]  ADDR_HP     = 8'h04;
    localparam logic [7:0]  ADDR_SRC    = 8'h1A;
    localparam logic [7:0]  ADDR_READ   = 8'h80;

    logic [1:0]       state_q, state_d;
    logic [3:0]       settleCnt_q, settleCnt_d;
    logic [2:0]       initIdx_q, initIdx_d;
    logic [7:0]       addr_q, addr_d;
    logic [15:0]      data_q, data_d;
    logic             valid_q, valid_d;
    logic             initDone_q, initDone_d;
    logic [VOL_W-1:0] pendVolL_q, pendVolL_d;
    logic [VOL_W-1:0] pendVolR_q, pendVolR_d;
    logic             pendMute_q, pendMute_d;
    logic [2:0]       pendSrc_q, pendSrc_d;
    logic [VOL_W-1:0] shVolL_q, shVolL_d;
    logic [VOL_W-1:0] shVolR_q, shVolR_d;
    logic             shMute_q, shMute_d;
    logic [2:0]       shSrc_q, shSrc_d;

    logic [4:0]  attL, attR;
    logic [15:0] hpWord, srcWord;
    logic        hpMis, srcMis;
    logic [2:0]  loadIdx;
    logic [23:0] loadCmd;

    // Gain-to-attenuation mapping: narrow volumes are left-aligned into 5 bits
    assign attL    = 5'd31 - (5'(volume_l) << VOL_SHIFT);
    assign attR    = 5'd31 - (5'(volume_r) << VOL_SHIFT);
    assign hpWord  = {mute, 2'b00, attL, 3'b000, attR};
    assign srcWord = {5'b00000, source, 5'b00000, source};
    assign hpMis   = {volume_l, volume_r, mute} != {shVolL_q, shVolR_q, shMute_q};
    assign srcMis  = source != shSrc_q;

    // Init table lookup for the entry about to be presented
    always_comb begin
        loadIdx = (state_q == ST_SETTLE) ? 3'd0 : initIdx_q + 3'd1;
        loadCmd = {ADDR_READ, 16'h0000};
        case (loadIdx)
            3'd0:    loadCmd = {ADDR_HP, hpWord};
            3'd1:    loadCmd = {8'h18, 3'b000, PCM_ATT, 3'b000, PCM_ATT};
            3'd2:    loadCmd = {ADDR_SRC, srcWord};
            3'd3:    loadCmd = {8'h1C, 16'h0F0F};
            3'd4:    loadCmd = {8'h0E, MIC_WORD};
            3'd5:    loadCmd = {8'h0A, 16'h0000};
            3'd6:    loadCmd = {8'h20, 16'h8000};
            default: loadCmd = {ADDR_READ, 16'h0000};
        endcase
    end

    // Sequencer next-state: a command is consumed only when ready meets valid
    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        initIdx_d   = initIdx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        valid_d     = valid_q;
        initDone_d  = initDone_q;
        pendVolL_d  = pendVolL_q;
        pendVolR_d  = pendVolR_q;
        pendMute_d  = pendMute_q;
        pendSrc_d   = pendSrc_q;
        shVolL_d    = shVolL_q;
        shVolR_d    = shVolR_q;
        shMute_d    = shMute_q;
        shSrc_d     = shSrc_q;
        case (state_q)
            ST_SETTLE: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                end else if (ready) begin
                    if (settleCnt_q == SETTLE_LAST) begin
                        state_d    = ST_INIT;
                        initIdx_d  = 3'd0;
                        {addr_d, data_d} = loadCmd;
                        pendVolL_d = volume_l;
                        pendVolR_d = volume_r;
                        pendMute_d = mute;
                    end else begin
                        settleCnt_d = settleCnt_q + 4'd1;
                    end
                end
            end
            ST_INIT: begin
                if (ready) begin
                    if (initIdx_q == 3'd0) begin
                        shVolL_d = pendVolL_q;
                        shVolR_d = pendVolR_q;
                        shMute_d = pendMute_q;
                    end
                    if (initIdx_q == 3'd2) begin
                        shSrc_d = pendSrc_q;
                    end
                    if (initIdx_q == INIT_LAST) begin
                        state_d    = ST_IDLE;
                        valid_d    = 1'b0;
                        addr_d     = ADDR_READ;
                        data_d     = 16'h0000;
                        initDone_d = 1'b1;
                    end else begin
                        initIdx_d = loadIdx;
                        {addr_d, data_d} = loadCmd;
                        if (loadIdx == 3'd2) begin
                            pendSrc_d = source;
                        end
                    end
                end
            end
            ST_IDLE: begin
                if (hpMis) begin
                    state_d    = ST_UPDATE;
                    valid_d    = 1'b1;
                    addr_d     = ADDR_HP;
                    data_d     = hpWord;
                    pendVolL_d = volume_l;
                    pendVolR_d = volume_r;
                    pendMute_d = mute;
                end else if (srcMis) begin
                    state_d   = ST_UPDATE;
                    valid_d   = 1'b1;
                    addr_d    = ADDR_SRC;
                    data_d    = srcWord;
                    pendSrc_d = source;
                end
            end
            default: begin
                if (ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    addr_d  = ADDR_READ;
                    data_d  = 16'h0000;
                    if (addr_q == ADDR_HP) begin
                        shVolL_d = pendVolL_q;
                        shVolR_d = pendVolR_q;
                        shMute_d = pendMute_q;
                        if (srcMis) begin
                            state_d   = ST_UPDATE;
                            valid_d   = 1'b1;
                            addr_d    = ADDR_SRC;
                            data_d    = srcWord;
                            pendSrc_d = source;
                        end
                    end else begin
                        shSrc_d = pendSrc_q;
                        if (hpMis) begin
                            state_d    = ST_UPDATE;
                            valid_d    = 1'b1;
                            addr_d     = ADDR_HP;
                            data_d     = hpWord;
                            pendVolL_d = volume_l;
                            pendVolR_d = volume_r;
                            pendMute_d = mute;
                        end
                    end
                end
            end
        endcase
    end

    // State, command and shadow registers with asynchronous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_SETTLE;
            settleCnt_q <= 4'd0;
            initIdx_q   <= 3'd0;
            addr_q      <= ADDR_READ;
            data_q      <= 16'h0000;
            valid_q     <= 1'b0;
            initDone_q  <= 1'b0;
            pendVolL_q  <= '0;
            pendVolR_q  <= '0;
            pendMute_q  <= 1'b0;
            pendSrc_q   <= 3'd0;
            shVolL_q    <= '0;
            shVolR_q    <= '0;
            shMute_q    <= 1'b0;
            shSrc_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            settleCnt_q <= settleCnt_d;
            initIdx_q   <= initIdx_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            initDone_q  <= initDone_d;
            pendVolL_q  <= pendVolL_d;
            pendVolR_q  <= pendVolR_d;
            pendMute_q  <= pendMute_d;
            pendSrc_q   <= pendSrc_d;
            shVolL_q    <= shVolL_d;
            shVolR_q    <= shVolR_d;
            shMute_q    <= shMute_d;
            shSrc_q     <= shSrc_d;
        end
    end

    assign command_address = addr_q;
    assign command_data    = data_q;
    assign command_valid   = valid_q;
    assign init_done       = initDone_q;

endmodule

// File: tb/tb_ac97_cmd_sequencer.sv
// Bench for the AC97 command sequencer: a behavioural model tracks the
// command stream, one process compares every cycle, plus literal checkpoints.
module tb_ac97_cmd_sequencer;

    localparam int SF       = 2;
    localparam int INIT_LEN = 7;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        ready;
    logic [4:0]  volume_l, volume_r;
    logic        mute;
    logic [2:0]  source;
    logic [7:0]  command_address;
    logic [15:0] command_data;
    logic        command_valid, init_done;

    logic [2:0]  vol3;
    logic [7:0]  addr3;
    logic [15:0] data3;
    logic        valid3, done3;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    // Model state
    bit          mStarted;
    int          seqPos;
    logic [4:0]  shL, shR, pL, pR;
    logic        shM, pM;
    logic [2:0]  shS, pS;
    bit          curIsHp;
    logic [7:0]  expAddr;
    logic [15:0] expData;
    logic        expValid, expDone;

    ac97_cmd_sequencer dut (
        .clock(clock), .reset_n(reset_n), .ready(ready),
        .volume_l(volume_l), .volume_r(volume_r), .mute(mute), .source(source),
        .command_address(command_address), .command_data(command_data),
        .command_valid(command_valid), .init_done(init_done)
    );

    ac97_cmd_sequencer #(.VOL_W(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .ready(ready),
        .volume_l(vol3), .volume_r(vol3), .mute(mute), .source(source),
        .command_address(addr3), .command_data(data3),
        .command_valid(valid3), .init_done(done3)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] hpData(input logic [4:0] l, input logic [4:0] r, input logic m);
        logic [4:0] aL, aR;
        aL = 5'd31 - l;
        aR = 5'd31 - r;
        return {m, 2'b00, aL, 3'b000, aR};
    endfunction

    function automatic logic [23:0] initEntry(input int k);
        case (k)
            0:       return {8'h04, hpData(volume_l, volume_r, mute)};
            1:       return 24'h18_0808;
            2:       return {8'h1A, 5'b0, source, 5'b0, source};
            3:       return 24'h1C_0F0F;
            4:       return 24'h0E_8048;
            5:       return 24'h0A_0000;
            default: return 24'h20_8000;
        endcase
    endfunction

    task automatic setExp(input logic [23:0] cmd, input logic v);
        {expAddr, expData} = cmd;
        expValid = v;
    endtask

    task automatic modelReset();
        mStarted = 1'b0;
        seqPos   = 0;
        shL = 5'd0; shR = 5'd0; shM = 1'b0; shS = 3'd0;
        pL  = 5'd0; pR  = 5'd0; pM  = 1'b0; pS  = 3'd0;
        curIsHp  = 1'b0;
        setExp(24'h80_0000, 1'b0);
        expDone  = 1'b0;
    endtask

    task automatic issueHp();
        pL = volume_l; pR = volume_r; pM = mute;
        curIsHp = 1'b1;
        setExp({8'h04, hpData(volume_l, volume_r, mute)}, 1'b1);
    endtask

    task automatic issueSrc();
        pS = source;
        curIsHp = 1'b0;
        setExp({8'h1A, 5'b0, source, 5'b0, source}, 1'b1);
    endtask

    // One clock edge of the reference behaviour, seen from the inputs
    task automatic modelStep();
        bit hpMis, srcMis;
        int k;
        if (!mStarted) begin
            mStarted = 1'b1;
            setExp(24'h80_0000, 1'b1);
        end else if (seqPos < SF + INIT_LEN) begin
            if (ready) begin
                if (seqPos == SF) begin shL = pL; shR = pR; shM = pM; end
                if (seqPos == SF + 2) shS = pS;
                seqPos++;
                if (seqPos == SF + INIT_LEN) begin
                    setExp(24'h80_0000, 1'b0);
                    expDone = 1'b1;
                end else if (seqPos < SF) begin
                    setExp(24'h80_0000, 1'b1);
                end else begin
                    k = seqPos - SF;
                    if (k == 0) begin pL = volume_l; pR = volume_r; pM = mute; end
                    if (k == 2) pS = source;
                    setExp(initEntry(k), 1'b1);
                end
            end
        end else if (expValid) begin
            if (ready) begin
                if (curIsHp) begin shL = pL; shR = pR; shM = pM; end
                else shS = pS;
                hpMis  = {volume_l, volume_r, mute} != {shL, shR, shM};
                srcMis = source != shS;
                if (curIsHp && srcMis) issueSrc();
                else if (!curIsHp && hpMis) issueHp();
                else setExp(24'h80_0000, 1'b0);
            end
        end else begin
            hpMis  = {volume_l, volume_r, mute} != {shL, shR, shM};
            srcMis = source != shS;
            if (hpMis) issueHp();
            else if (srcMis) issueSrc();
        end
    endtask

    // Drive inputs at the falling edge, advance the model at the rising edge
    task automatic applyStimulus(input logic r, input logic [4:0] vl, input logic [4:0] vr,
                                 input logic m, input logic [2:0] s);
        ready = r; volume_l = vl; volume_r = vr; mute = m; source = s;
        @(posedge clock);
        if (reset_n) modelStep();
        @(negedge clock);
    endtask

    task automatic pulseReset();
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset", 32'({command_valid, init_done, command_address, command_data}),
                    32'({1'b0, 1'b0, 24'h80_0000}));
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("cmd", 32'({command_valid, command_address, command_data}),
                        32'({expValid, expAddr, expData}));
            checkOutput("init_done", 32'(init_done), 32'(expDone));
        end
    end

    initial begin
        logic [23:0] initSeq [9];
        initSeq = '{24'h80_0000, 24'h80_0000, 24'h04_0000, 24'h18_0808, 24'h1A_0000,
                    24'h1C_0F0F, 24'h0E_8048, 24'h0A_0000, 24'h20_8000};
        reset_n = 1'b0; ready = 1'b0; volume_l = 5'd31; volume_r = 5'd31;
        mute = 1'b0; source = 3'd0; vol3 = 3'b111;
        modelReset();
        checkEn = 1'b1;
        @(negedge clock);
        checkOutput("reset_state", 32'({command_valid, init_done, command_address, command_data}),
                    32'({1'b0, 1'b0, 24'h80_0000}));
        reset_n = 1'b1;

        // Default init sequence with ready held high
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 5'd31, 5'd31, 1'b0, 3'd0);
            checkOutput($sformatf("init_seq_%0d", i),
                        32'({command_valid, command_address, command_data}), 32'({1'b1, initSeq[i]}));
            if (i == 2)
                checkOutput("volw3_hp", 32'({valid3, done3, addr3, data3}), 32'({1'b1, 1'b0, 24'h04_0303}));
        end
        applyStimulus(1'b1, 5'd31, 5'd31, 1'b0, 3'd0);
        checkOutput("init_end", 32'({command_valid, init_done, command_address, command_data}),
                    32'({1'b1 ^ 1'b1, 1'b1, 24'h80_0000}));

        // Left volume to zero
        applyStimulus(1'b0, 5'd0, 5'd31, 1'b0, 3'd0);
        checkOutput("vol_update", 32'({command_valid, command_address, command_data}), 32'({1'b1, 24'h04_1F00}));
        applyStimulus(1'b1, 5'd0, 5'd31, 1'b0, 3'd0);
        checkOutput("vol_idle", 32'({command_valid, command_address, command_data}), 32'({1'b0, 24'h80_0000}));

        // Mute and source together: headphone first, then source
        applyStimulus(1'b0, 5'd31, 5'd31, 1'b1, 3'd4);
        checkOutput("mute_hp", 32'({command_valid, command_address, command_data}), 32'({1'b1, 24'h04_8000}));
        applyStimulus(1'b1, 5'd31, 5'd31, 1'b1, 3'd4);
        checkOutput("mute_src", 32'({command_valid, command_address, command_data}), 32'({1'b1, 24'h1A_0404}));
        applyStimulus(1'b1, 5'd31, 5'd31, 1'b1, 3'd4);
        checkOutput("mute_idle", 32'({command_valid, command_address, command_data}), 32'({1'b0, 24'h80_0000}));

        // A pending command holds while inputs move; the change follows later
        applyStimulus(1'b0, 5'd10, 5'd31, 1'b1, 3'd4);
        checkOutput("pend_first", 32'({command_valid, command_address, command_data}), 32'({1'b1, 24'h04_9500}));
        applyStimulus(1'b0, 5'd20, 5'd31, 1'b1, 3'd4);
        checkOutput("pend_hold", 32'({command_valid, command_address, command_data}), 32'({1'b1, 24'h04_9500}));
        applyStimulus(1'b1, 5'd20, 5'd31, 1'b1, 3'd4);
        checkOutput("pend_gap", 32'({command_valid, command_address, command_data}), 32'({1'b0, 24'h80_0000}));
        applyStimulus(1'b0, 5'd20, 5'd31, 1'b1, 3'd4);
        checkOutput("pend_again", 32'({command_valid, command_address, command_data}), 32'({1'b1, 24'h04_8B00}));

        // Reset mid-update, then reset again after the third init write
        pulseReset();
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 5'd31, 5'd31, 1'b0, 3'd0);
        checkOutput("third_write", 32'({command_valid, command_address, command_data}), 32'({1'b1, 24'h1C_0F0F}));
        pulseReset();

        // Restart with ready held high and a volume change during init
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, (i >= 5) ? 5'd7 : 5'd31, 5'd31, 1'b0, 3'd0);
            if (i == 0)
                checkOutput("restart", 32'({command_valid, command_address, command_data}), 32'({1'b1, 24'h80_0000}));
            if (i == 10)
                checkOutput("late_update", 32'({command_valid, command_address, command_data}), 32'({1'b1, 24'h04_1800}));
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] vl, vr;
            logic       m;
            logic [2:0] s;
            vl = volume_l; vr = volume_r; m = mute; s = source;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: vl = 5'($urandom_range(0, 31));
                    1: vr = 5'($urandom_range(0, 31));
                    2: m  = ~m;
                    default: s = 3'($urandom_range(0, 7));
                endcase
            end
            if ($urandom_range(0, 199) == 0) pulseReset();
            applyStimulus(1'($urandom_range(0, 1)), vl, vr, m, s);
        end

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
